// File: rtl/oflow_fsm_write_if.sv
// oflow_fsm_write_if
// Line handshake and buffer write bus between upstream, the write controller
// and the history frame buffer.
//   data_valid, last_line : upstream offers a line / marks end of frame
//   ready                 : controller accepts lines (write_st)
//   we, wr_slot, wr_addr  : buffer write enable, slot index and line offset
// The controller uses the slave modport; the upstream/buffer side uses master.
interface oflow_fsm_write_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int SLOT_WIDTH = 3
);
  logic                  data_valid;
  logic                  last_line;
  logic                  ready;
  logic                  we;
  logic [SLOT_WIDTH-1:0] wr_slot;
  logic [ADDR_WIDTH-1:0] wr_addr;

  modport slave (
    input  data_valid,
    input  last_line,
    output ready,
    output we,
    output wr_slot,
    output wr_addr
  );

  modport master (
    output data_valid,
    output last_line,
    input  ready,
    input  we,
    input  wr_slot,
    input  wr_addr
  );
endinterface

// File: rtl/oflow_fsm_write.sv
// oflow_fsm_write
// Write-side controller of the optical-flow history frame buffer. Accepts the
// lines of one frame, writes them to consecutive offsets of slot
// frame_num % max(num_of_history_frames,1) and records the line count of that
// slot in end_pointers for the read FSM.
// Ports:
//   clk                   : clock, all logic on posedge
//   reset_N               : asynchronous reset, active high
//   frame_num             : serial number of the frame, sampled on start
//   num_of_history_frames : slot modulus, sampled on start (0 behaves as 1)
//   start_write           : one-cycle pulse beginning a frame (idle only)
//   bus                   : line handshake + buffer write bus (slave side)
//   end_pointers          : per-slot line count, 0 = empty slot
//   done_write            : one-cycle pulse in the commit cycle
//   overflow              : sticky, frame truncated at capacity
module oflow_fsm_write #(
  parameter int ADDR_WIDTH                  = 6,
  parameter int NUM_SLOTS                   = 5,
  parameter int SLOT_WIDTH                  = 3,
  parameter int TOTAL_FRAME_NUM_WIDTH       = 8,
  parameter int NUM_OF_HISTORY_FRAMES_WIDTH = 4
) (
  input  logic                                   clk,
  input  logic                                   reset_N,
  input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
  input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
  input  logic                                   start_write,
  oflow_fsm_write_if.slave                       bus,
  output logic [ADDR_WIDTH-1:0]                  end_pointers [NUM_SLOTS],
  output logic                                   done_write,
  output logic                                   overflow
);

  // Offset of the last line a slot can hold; writing it ends the frame so the
  // count never exceeds 2^ADDR_WIDTH-1.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    idle_st   = 2'd0,
    write_st  = 2'd1,
    commit_st = 2'd2
  } state_t;

  state_t                             state_r;
  state_t                             state_s;
  logic [SLOT_WIDTH-1:0]              slot_r;
  logic [ADDR_WIDTH-1:0]              line_cnt_r;
  logic [ADDR_WIDTH-1:0]              next_cnt_s;
  logic                               we_s;
  logic                               commit_s;
  logic                               ovf_set_s;
  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] modulus_s;
  logic [TOTAL_FRAME_NUM_WIDTH-1:0]   modulus_wide_s;
  logic [TOTAL_FRAME_NUM_WIDTH-1:0]   remainder_s;
  logic [SLOT_WIDTH-1:0]              start_slot_s;

  // Slot selected by the frame serial number; a zero modulus acts as 1.
  always_comb begin
    modulus_s      = num_of_history_frames;
    if (num_of_history_frames == {NUM_OF_HISTORY_FRAMES_WIDTH{1'b0}}) begin
      modulus_s = {{(NUM_OF_HISTORY_FRAMES_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      modulus_s = num_of_history_frames;
    end
    modulus_wide_s = TOTAL_FRAME_NUM_WIDTH'(modulus_s);
    remainder_s    = frame_num % modulus_wide_s;
    start_slot_s   = SLOT_WIDTH'(remainder_s);
  end

  // Next state, frame termination and capacity truncation.
  always_comb begin
    state_s   = state_r;
    we_s      = 1'b0;
    commit_s  = 1'b0;
    ovf_set_s = 1'b0;
    case (state_r)
      idle_st: begin
        if (start_write) begin
          state_s = write_st;
        end else begin
          state_s = idle_st;
        end
      end
      write_st: begin
        we_s = bus.data_valid;
        if (bus.data_valid) begin
          if (bus.last_line) begin
            commit_s = 1'b1;
          end else if (line_cnt_r == LAST_ADDR) begin
            // Slot full: this line is forced to be the last one.
            commit_s  = 1'b1;
            ovf_set_s = 1'b1;
          end else begin
            commit_s = 1'b0;
          end
        end else if (bus.last_line) begin
          // End of frame without a line (empty frame or trailing marker).
          commit_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
        if (commit_s) begin
          state_s = commit_st;
        end else begin
          state_s = write_st;
        end
      end
      commit_st: state_s = idle_st;
      default:   state_s = idle_st;
    endcase
  end

  // Count after the current cycle's write, used for the pointer commit.
  always_comb begin
    if (we_s) begin
      next_cnt_s = line_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      next_cnt_s = line_cnt_r;
    end
  end

  // Handshake and write bus outputs; address/slot are held at 0 outside a frame.
  always_comb begin
    bus.ready   = 1'b0;
    bus.we      = 1'b0;
    bus.wr_slot = {SLOT_WIDTH{1'b0}};
    bus.wr_addr = {ADDR_WIDTH{1'b0}};
    done_write  = 1'b0;
    if (state_r == write_st) begin
      bus.ready   = 1'b1;
      bus.we      = we_s;
      bus.wr_slot = slot_r;
      bus.wr_addr = line_cnt_r;
    end else begin
      done_write = (state_r == commit_st);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      state_r <= idle_st;
    end else begin
      state_r <= state_s;
    end
  end

  // Frame context, line counter, overflow flag and per-slot line counts.
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      slot_r     <= {SLOT_WIDTH{1'b0}};
      line_cnt_r <= {ADDR_WIDTH{1'b0}};
      overflow   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        end_pointers[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else if (state_r == idle_st && start_write) begin
      slot_r     <= start_slot_s;
      line_cnt_r <= {ADDR_WIDTH{1'b0}};
      overflow   <= 1'b0;
    end else begin
      line_cnt_r <= next_cnt_s;
      if (ovf_set_s) begin
        overflow <= 1'b1;
      end
      if (commit_s) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (slot_r == SLOT_WIDTH'(i)) begin
            end_pointers[i] <= next_cnt_s;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_oflow_fsm_write.sv
// tb_oflow_fsm_write
// Directed sequence of frames with randomized line gaps, lengths and
// mid-frame input noise, checked against a slot/count model of the buffer.
module tb_oflow_fsm_write;
  localparam int AW       = 6;
  localparam int NS       = 5;
  localparam int SW       = 3;
  localparam int TW       = 8;
  localparam int HW       = 4;
  localparam int CAP_LAST = (1 << AW) - 2;

  logic          clk = 1'b0;
  logic          reset_N;
  logic [TW-1:0] frame_num;
  logic [HW-1:0] nh;
  logic          start_write;
  logic [AW-1:0] end_pointers [NS];
  logic          done_write;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  int ep_model [NS];

  oflow_fsm_write_if #(.ADDR_WIDTH(AW), .SLOT_WIDTH(SW)) bus ();

  oflow_fsm_write #(
    .ADDR_WIDTH(AW), .NUM_SLOTS(NS), .SLOT_WIDTH(SW),
    .TOTAL_FRAME_NUM_WIDTH(TW), .NUM_OF_HISTORY_FRAMES_WIDTH(HW)
  ) dut (
    .clk(clk),
    .reset_N(reset_N),
    .frame_num(frame_num),
    .num_of_history_frames(nh),
    .start_write(start_write),
    .bus(bus.slave),
    .end_pointers(end_pointers),
    .done_write(done_write),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ep(input string tag);
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("%s_ep%0d", tag, i), 32'(end_pointers[i]), 32'(ep_model[i]));
    end
  endtask

  // One frame: start pulse, lines (gaps with probability gap_pct%), end marker
  // either on the last data line or as a data-less marker after nlines lines.
  // poke adds random start_write pulses during the frame.
  task automatic run_frame(input int fnum, input int hist, input int nlines,
                           input bit last_with_data, input int gap_pct, input bit poke);
    int slot;
    int sent;
    int cyc;
    bit ended;
    bit exp_ovf;
    bit dv;
    bit ll;
    slot        = fnum % ((hist == 0) ? 1 : hist);
    frame_num   = TW'(fnum);
    nh          = HW'(hist);
    start_write = 1'b1;
    bus.data_valid = 1'($urandom_range(0, 1));
    bus.last_line  = 1'($urandom_range(0, 1));
    #1;
    chk("idle_ready", 32'(bus.ready), 32'd0);
    chk("idle_we", 32'(bus.we), 32'd0);
    chk("idle_done", 32'(done_write), 32'd0);
    @(negedge clk);
    start_write = 1'b0;
    sent    = 0;
    ended   = 1'b0;
    exp_ovf = 1'b0;
    cyc     = 0;
    while (!ended && cyc < 300) begin
      cyc++;
      frame_num   = TW'($urandom);
      nh          = HW'($urandom_range(0, NS));
      start_write = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!last_with_data && sent == nlines) begin
        dv = 1'b0;
        ll = 1'b1;
      end else begin
        dv = ($urandom_range(0, 99) >= gap_pct);
        ll = dv && last_with_data && (sent == nlines - 1);
      end
      bus.data_valid = dv;
      bus.last_line  = ll;
      #1;
      chk("wr_ready", 32'(bus.ready), 32'd1);
      chk("wr_we", 32'(bus.we), 32'(dv));
      chk("wr_done", 32'(done_write), 32'd0);
      chk("wr_ovf", 32'(overflow), 32'd0);
      if (dv) begin
        chk("wr_addr", 32'(bus.wr_addr), 32'(sent));
        chk("wr_slot", 32'(bus.wr_slot), 32'(slot));
        if (!ll && sent == CAP_LAST) exp_ovf = 1'b1;
        if (ll || sent == CAP_LAST) ended = 1'b1;
        sent++;
      end else if (ll) begin
        ended = 1'b1;
      end
      @(negedge clk);
    end
    start_write    = 1'b0;
    bus.data_valid = 1'b0;
    bus.last_line  = 1'b0;
    ep_model[slot] = sent;
    chk("commit_done", 32'(done_write), 32'd1);
    chk("commit_ready", 32'(bus.ready), 32'd0);
    chk("commit_we", 32'(bus.we), 32'd0);
    chk("commit_ovf", 32'(overflow), 32'(exp_ovf));
    chk_ep("commit");
    @(negedge clk);
    chk("post_done", 32'(done_write), 32'd0);
    chk("post_ready", 32'(bus.ready), 32'd0);
    chk("post_ovf", 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    int lines;
    for (int i = 0; i < NS; i++) ep_model[i] = 0;
    reset_N        = 1'b1;
    frame_num      = '0;
    nh             = '0;
    start_write    = 1'b0;
    bus.data_valid = 1'b0;
    bus.last_line  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_slot", 32'(bus.wr_slot), 32'd0);
    chk("rst_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_done", 32'(done_write), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk_ep("rst");
    reset_N = 1'b0;
    @(negedge clk);

    // Normal frame, then a frame into slot 3, then an empty frame clearing it.
    run_frame(7, 5, 3, 1'b1, 0, 1'b0);
    run_frame(3, 5, 4, 1'b1, 0, 1'b0);
    run_frame(8, 5, 0, 1'b0, 0, 1'b0);

    // Wrap-around: frames 0..6 through five slots.
    for (int f = 0; f < 7; f++) begin
      run_frame(f, 5, 2, 1'($urandom_range(0, 1)), 0, 1'b0);
    end

    // Capacity truncation.
    run_frame(9, 5, 70, 1'b1, 0, 1'b0);

    // Gaps plus ignored start pulses.
    run_frame($urandom_range(0, 255), $urandom_range(0, NS), $urandom_range(1, 20), 1'b1, 30, 1'b1);

    // Random frames, including zero modulus and empty frames.
    repeat (8) begin
      lines = $urandom_range(0, 30);
      run_frame($urandom_range(0, 255), $urandom_range(0, NS), lines,
                (lines == 0) ? 1'b0 : 1'($urandom_range(0, 1)),
                $urandom_range(0, 50), 1'($urandom_range(0, 1)));
    end

    // Reset after two writes of a frame.
    frame_num   = 8'd11;
    nh          = 4'd4;
    start_write = 1'b1;
    @(negedge clk);
    start_write    = 1'b0;
    bus.data_valid = 1'b1;
    #1;
    chk("mid_addr0", 32'(bus.wr_addr), 32'd0);
    @(negedge clk);
    #1;
    chk("mid_addr1", 32'(bus.wr_addr), 32'd1);
    @(negedge clk);
    reset_N = 1'b1;
    #1;
    for (int i = 0; i < NS; i++) ep_model[i] = 0;
    chk("mrst_ready", 32'(bus.ready), 32'd0);
    chk("mrst_we", 32'(bus.we), 32'd0);
    chk("mrst_slot", 32'(bus.wr_slot), 32'd0);
    chk("mrst_addr", 32'(bus.wr_addr), 32'd0);
    chk("mrst_done", 32'(done_write), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    chk_ep("mrst");
    @(negedge clk);
    reset_N        = 1'b0;
    bus.data_valid = 1'b0;
    @(negedge clk);
    run_frame(12, 5, 3, 1'b1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oflow_fsm_write.md
# oflow_fsm_write

Write-side controller for the optical-flow history frame buffer. Accepts one frame's object lines from upstream with a valid/ready handshake, writes them to consecutive offsets of the circular slot `frame_num % num_of_history_frames`, and records each slot's line count in `end_pointers`. The read FSM, which walks previous frames, consumes `end_pointers` to bound its offset loop. Sits in the MEM buffer wrapper beside the read FSM.

## Interface
Parameters:
- `ADDR_WIDTH`, default 6: offset width; a slot holds at most 2^ADDR_WIDTH-1 lines.
- `NUM_SLOTS`, default 5: number of frame slots; also the number of `end_pointers` entries.
- `SLOT_WIDTH`, default 3: slot index width (≥ clog2(NUM_SLOTS)).
- `TOTAL_FRAME_NUM_WIDTH`, default 8: frame serial number width.
- `NUM_OF_HISTORY_FRAMES_WIDTH`, default 4: width of the history-depth input.

Ports:
- `clk` in 1: single clock; everything is posedge.
- `reset_N` in 1: asynchronous, active-high reset (asserted = 1).
- `frame_num` in TOTAL_FRAME_NUM_WIDTH: serial number of the current frame.
- `num_of_history_frames` in NUM_OF_HISTORY_FRAMES_WIDTH: slot modulus. Legal range is 1..NUM_SLOTS; a value of 0 is treated as 1.
- `start_write` in 1: one-cycle pulse that begins a frame.
- `data_valid` in 1: upstream presents one line.
- `last_line` in 1: marks the end of the frame. Meaning is given under Operation.
- `ready` out 1: the block can accept a line.
- `we` out 1: buffer write enable.
- `wr_slot` out SLOT_WIDTH: slot being written.
- `wr_addr` out ADDR_WIDTH: offset being written.
- `end_pointers` out [NUM_SLOTS][ADDR_WIDTH]: line count per slot. 0 means the slot is empty.
- `done_write` out 1: one-cycle pulse when a frame is committed.
- `overflow` out 1: sticky flag; the frame was truncated.

## Operation
- States: `idle_st`, `write_st`, `commit_st`. Reset state is `idle_st`.
- `idle_st`:
  - `ready`=0 and `we`=0.
  - On `start_write`, latch `slot_reg = frame_num % max(num_of_history_frames,1)`, clear `line_cnt`, clear `overflow`, and go to `write_st`.
  - All other inputs are ignored.
- `write_st`:
  - `ready`=1.
  - `we = data_valid`, `wr_slot = slot_reg`, `wr_addr = line_cnt`, all combinational.
  - When `we`=1, `line_cnt` increments.
- Frame end:
  - `data_valid`=1 with `last_line`=1: the line is written, then the FSM goes to `commit_st`.
  - `data_valid`=0 with `last_line`=1: end of frame with no extra line. Nothing is written; the FSM goes to `commit_st`. This is how an empty frame is committed (count 0).
- Capacity limit:
  - The line written at `wr_addr` = 2^ADDR_WIDTH-2 is forced last.
  - If `last_line`=0 on that line, `overflow` is set and the FSM still goes to `commit_st`. The count saturates at 2^ADDR_WIDTH-1.
- `commit_st`:
  - `done_write`=1 and `ready`=0.
  - Next state is `idle_st`.
- `end_pointers[slot_reg]` is loaded with the final `line_cnt` on the edge that enters `commit_st`. The other entries are unchanged.
- `start_write` outside `idle_st` is ignored.
- `frame_num` and `num_of_history_frames` are sampled only at start; later changes do not move `wr_slot`.
- Slot wrap: consecutive frames cycle through slots 0..N-1 and overwrite the oldest slot's pointer. This matches the read side, which reads slot `(frame_num-k-1) % N`.
- Reset mid-frame: the partial frame is discarded. All `end_pointers` go to 0, `overflow` to 0, and the state to `idle_st`.

## Timing
- Reset values: `ready`=0, `we`=0, `wr_slot`=0, `wr_addr`=0, `done_write`=0, `overflow`=0, all `end_pointers`=0.
- Handshake: a line transfers in any cycle with `ready`=1 and `data_valid`=1. There is no backpressure inside a frame, so throughput is 1 line/cycle.
- `start_write` at edge T:
  - `ready`=1 from T+1.
  - The first write can occur in cycle T+1 at `wr_addr`=0.
- Terminating handshake at edge E:
  - `commit_st` in cycle E+1: `done_write`=1 and the updated `end_pointers` are visible.
  - `idle_st` from E+2.
  - The earliest next `start_write` is accepted in cycle E+2.
- Frame overhead: 2 cycles (start and commit) plus the number of lines.
- `overflow` is set on the edge of the truncating write. It holds until the next accepted `start_write`.

## Test plan
- Normal frame: N=5, `frame_num`=7, 3 lines with `last_line` on the third → writes to slot 2 at addrs 0,1,2; `end_pointers[2]`=3; `done_write` 1 cycle after the last write.
- Empty frame: `start_write`, then `last_line`=1 with `data_valid`=0 → no `we`; `end_pointers[slot]`=0; `done_write` pulses.
- Wrap-around: `frame_num` 0..6 with N=5, 2 lines each → frames 5 and 6 overwrite `end_pointers[0]` and `[1]`; other entries keep their values.
- Overflow: ADDR_WIDTH=6, 70 valid lines without `last_line` → 63 writes (addr 0..62); `overflow`=1; `end_pointers[slot]`=63; `ready`=0 afterwards.
- Gaps and ignored start: `data_valid` bubbles mid-frame plus `start_write` during `write_st` → addresses stay contiguous; slot unchanged; count correct.
- Reset mid-frame after 2 writes → all outputs and `end_pointers` return to 0; the next frame starts cleanly at addr 0.
